// File: rtl/spi_tx_arbiter_if.sv
// Bundles the per-source streams and the SPI-side byte port of spi_tx_arbiter.
// The master modport is the arbiter; the slave modport is the sources plus the SPI slave.
interface spi_tx_arbiter_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_SRC = 3
);
  logic [NUM_SRC*WIDTH-1:0] s_data;
  logic [NUM_SRC-1:0]       s_vld;
  logic [NUM_SRC-1:0]       s_last;
  logic [NUM_SRC-1:0]       s_rdy;
  logic [WIDTH-1:0]         m_data;
  logic                     m_vld;
  logic                     m_last;
  logic                     m_rdy;
  logic [3:0]               grant_id;
  logic                     busy;

  modport master (
    input  s_data, s_vld, s_last, m_rdy,
    output s_rdy, m_data, m_vld, m_last, grant_id, busy
  );

  modport slave (
    output s_data, s_vld, s_last, m_rdy,
    input  s_rdy, m_data, m_vld, m_last, grant_id, busy
  );
endinterface

// File: rtl/spi_tx_arbiter.sv
// Packet-level round-robin arbiter feeding the SPI slave write port through a
// single registered output stage, with an optional per-packet source header.
module spi_tx_arbiter #(
  parameter int             WIDTH    = 8,
  parameter int             NUM_SRC  = 3,
  parameter bit             HDR_EN   = 1'b1,
  parameter logic [WIDTH-1:0] HDR_BASE = WIDTH'(8'hF0)
) (
  input  logic             clk,
  input  logic             reset,
  spi_tx_arbiter_if.master bus
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {IDLE, HEADER, DATA} state_e;

  state_e           state_q, state_d;
  logic [3:0]       rr_q, rr_d;
  logic [3:0]       grant_q, grant_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic             m_vld_q, m_vld_d;
  logic             m_last_q, m_last_d;
  logic [NUM_SRC-1:0] s_rdy;
  logic             out_free;
  logic             found;
  logic [4:0]       cand;
  logic [IW-1:0]    gsel;

  assign out_free = ~m_vld_q | bus.m_rdy;

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    grant_d  = grant_q;
    m_data_d = m_data_q;
    m_last_d = m_last_q;
    m_vld_d  = m_vld_q & ~bus.m_rdy;
    s_rdy    = '0;
    found    = 1'b0;
    cand     = '0;
    gsel     = grant_q[IW-1:0];

    unique case (state_q)
      IDLE: begin
        // Search rr+1, rr+2, ... with wrap; the first requester found wins.
        for (int unsigned i = 1; i <= NUM_SRC; i++) begin
          cand = {1'b0, rr_q} + 5'(i);
          if (cand >= 5'(NUM_SRC)) cand = cand - 5'(NUM_SRC);
          if (!found && bus.s_vld[cand[IW-1:0]]) begin
            found   = 1'b1;
            grant_d = cand[3:0];
          end
        end
        if (found) state_d = HDR_EN ? HEADER : DATA;
      end

      HEADER: begin
        if (out_free) begin
          m_data_d = HDR_BASE | WIDTH'(grant_q);
          m_vld_d  = 1'b1;
          m_last_d = 1'b0;
          state_d  = DATA;
        end
      end

      DATA: begin
        s_rdy[gsel] = out_free;
        if (out_free && bus.s_vld[gsel]) begin
          m_data_d = bus.s_data[gsel*WIDTH +: WIDTH];
          m_vld_d  = 1'b1;
          m_last_d = bus.s_last[gsel];
          if (bus.s_last[gsel]) begin
            rr_d    = grant_q;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_q     <= 4'(NUM_SRC - 1);
      grant_q  <= '0;
      m_data_q <= '0;
      m_vld_q  <= 1'b0;
      m_last_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      grant_q  <= grant_d;
      m_data_q <= m_data_d;
      m_vld_q  <= m_vld_d;
      m_last_q <= m_last_d;
    end
  end

  assign bus.s_rdy    = s_rdy;
  assign bus.m_data   = m_data_q;
  assign bus.m_vld    = m_vld_q;
  assign bus.m_last   = m_last_q;
  assign bus.grant_id = grant_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Directed bench for spi_tx_arbiter: a packet-level round-robin model predicts
// the output byte stream, plus literal expectations for each scenario.
module tb_spi_tx_arbiter;
  localparam int W = 8;
  localparam int N = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_tx_arbiter_if #(.WIDTH(W), .NUM_SRC(N)) bus  ();
  spi_tx_arbiter_if #(.WIDTH(W), .NUM_SRC(N)) bus0 ();

  spi_tx_arbiter #(.WIDTH(W), .NUM_SRC(N), .HDR_EN(1'b1), .HDR_BASE(8'hF0)) u_dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  spi_tx_arbiter #(.WIDTH(W), .NUM_SRC(N), .HDR_EN(1'b0), .HDR_BASE(8'hF0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Source-side stimulus state (owned by the main process).
  int         plen[N];
  logic [7:0] pbuf[N][8];
  int         ppos[N];
  bit         pact[N];
  int         pdly[N];
  int         pstall[N];
  int         stall_at[N];
  int         stall_len[N];
  int         sub_seq[N];
  int         first_vld[N];
  int         first_rdy[N];
  int         cyc = 0;
  int         rdy_mode = 0;
  bit         stall_chk = 1'b0;
  bit [N-1:0] just_done = '0;

  // Model state (owned by the monitor process).
  int         taken_seq[N];
  int         mrr = N - 1;
  logic [8:0] exp_q[$];
  logic [7:0] log_d[$];
  logic       log_l[$];

  task automatic load(input int s, input int len, input logic [63:0] bytes, input int dly);
    plen[s] = len;
    for (int k = 0; k < 8; k++) pbuf[s][k] = bytes[8*k +: 8];
    ppos[s] = 0; pact[s] = 1'b1; pdly[s] = dly; pstall[s] = 0;
    stall_at[s] = 0; stall_len[s] = 0; first_vld[s] = -1; first_rdy[s] = -1;
  endtask

  function automatic bit pending();
    bit p;
    p = (exp_q.size() != 0) || bus.m_vld;
    for (int s = 0; s < N; s++) if (pact[s] || sub_seq[s] != taken_seq[s]) p = 1'b1;
    return p;
  endfunction

  task automatic cycle_src();
    logic [N-1:0] v;
    logic [N-1:0] acc;
    for (int s = 0; s < N; s++) begin
      v[s] = pact[s] && pdly[s] == 0 && pstall[s] == 0;
      if (v[s] && first_vld[s] < 0) begin first_vld[s] = cyc; sub_seq[s]++; end
      bus.s_data[s*W +: W] = v[s] ? pbuf[s][ppos[s]] : 8'h00;
      bus.s_last[s] = v[s] && (ppos[s] == plen[s] - 1);
    end
    bus.s_vld = v;
    bus.m_rdy = (rdy_mode == 0) ? 1'b1 : (cyc % 3 == 0);
    @(negedge clk);
    if (just_done != '0) begin chk("busy_bubble", bus.busy, 0); just_done = '0; end
    if (stall_chk && pstall[2] > 0) chk("stall_no_rdy0", bus.s_rdy[0], 0);
    for (int s = 0; s < N; s++)
      if (bus.s_rdy[s] && first_rdy[s] < 0 && first_vld[s] >= 0) first_rdy[s] = cyc;
    acc = v & bus.s_rdy;
    @(posedge clk); #1;
    cyc++;
    for (int s = 0; s < N; s++) begin
      if (pdly[s] > 0) pdly[s]--;
      else if (pstall[s] > 0) pstall[s]--;
      else if (acc[s]) begin
        ppos[s]++;
        if (ppos[s] == plen[s]) begin pact[s] = 1'b0; just_done[s] = 1'b1; end
        else if (stall_len[s] > 0 && ppos[s] == stall_at[s]) begin
          pstall[s] = stall_len[s]; stall_len[s] = 0;
        end
      end
    end
  endtask

  task automatic run(input int budget, input int stop_src, input int stop_pos);
    int n;
    n = 0;
    while (n < budget) begin
      if (stop_src >= 0) begin
        if (ppos[stop_src] >= stop_pos) break;
      end else if (!pending()) break;
      cycle_src();
      n++;
    end
    if (stop_src < 0) chk("drain_done", pending(), 0);
    else chk("stop_reached", ppos[stop_src] >= stop_pos, 1);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    for (int s = 0; s < N; s++) pact[s] = 1'b0;
    bus.s_vld = '0; bus.s_last = '0; bus.m_rdy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Output monitor: packet-level round-robin model picks the next source when a packet starts.
  initial begin
    logic       hold;
    logic [7:0] hd;
    logic       hl;
    logic [8:0] e;
    bit         got;
    int         c;
    hold = 1'b0; hd = '0; hl = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        mrr = N - 1;
        for (int s = 0; s < N; s++) taken_seq[s] = sub_seq[s];
        hold = 1'b0;
      end else begin
        chk("s_rdy_onehot0", $onehot0(bus.s_rdy), 1);
        if (hold) chk("hold_stable", {bus.m_vld, bus.m_last, bus.m_data}, {1'b1, hl, hd});
        if (bus.m_vld && bus.m_rdy) begin
          if (exp_q.size() == 0) begin
            got = 1'b0;
            for (int k = 1; k <= N; k++) begin
              c = (mrr + k) % N;
              if (!got && sub_seq[c] != taken_seq[c]) begin
                got = 1'b1;
                taken_seq[c]++;
                mrr = c;
                exp_q.push_back({1'b0, 8'hF0 | 8'(c)});
                for (int j = 0; j < plen[c]; j++) exp_q.push_back({(j == plen[c] - 1), pbuf[c][j]});
              end
            end
          end
          if (exp_q.size() == 0) chk("unexpected_byte", exp_q.size(), 1);
          else begin
            e = exp_q.pop_front();
            chk("m_data", bus.m_data, e[7:0]);
            chk("m_last", bus.m_last, e[8]);
            log_d.push_back(bus.m_data);
            log_l.push_back(bus.m_last);
          end
        end
        hold = bus.m_vld && !bus.m_rdy;
        hd = bus.m_data;
        hl = bus.m_last;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         base;
    int         n;
    bit         got;
    logic [7:0] t1e[4];
    logic [7:0] t3e[5];
    t1e = '{8'hF1, 8'h11, 8'h22, 8'h33};
    t3e = '{8'hF1, 8'h61, 8'h62, 8'h63, 8'h64};
    for (int s = 0; s < N; s++) begin
      pact[s] = 1'b0; sub_seq[s] = 0; taken_seq[s] = 0; ppos[s] = 0; plen[s] = 0;
      pdly[s] = 0; pstall[s] = 0; stall_at[s] = 0; stall_len[s] = 0;
      first_vld[s] = -1; first_rdy[s] = -1;
    end
    reset = 1'b1;
    bus.s_vld = '0; bus.s_data = '0; bus.s_last = '0; bus.m_rdy = 1'b1;
    bus0.s_vld = '0; bus0.s_data = '0; bus0.s_last = '0; bus0.m_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_m_vld", bus.m_vld, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_m_last", bus.m_last, 0);
    chk("rst_s_rdy", bus.s_rdy, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_grant_id", bus.grant_id, 0);
    chk("rst0_m_vld", bus0.m_vld, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single source: src1 sends 11,22,33.
    base = log_d.size();
    load(1, 3, 64'h33_22_11, 0);
    run(60, -1, 0);
    for (int k = 0; k < 4; k++) begin
      chk("t1_seq", log_d[base+k], t1e[k]);
      chk("t1_last", log_l[base+k], (k == 3));
    end
    chk("t1_latency", first_rdy[1] - first_vld[1], 2);
    reset_pulse();

    // Contention after reset: order 0,1,2, then src0 before src2.
    base = log_d.size();
    load(0, 2, 64'h11_10, 0);
    load(1, 2, 64'h21_20, 0);
    load(2, 2, 64'h31_30, 0);
    run(80, -1, 0);
    chk("t2_hdr0", log_d[base], 8'hF0);
    chk("t2_hdr1", log_d[base+3], 8'hF1);
    chk("t2_hdr2", log_d[base+6], 8'hF2);
    chk("t2_len", log_d.size() - base, 9);
    base = log_d.size();
    load(0, 2, 64'h41_40, 0);
    load(2, 2, 64'h51_50, 0);
    run(60, -1, 0);
    chk("t2_rr_first", log_d[base], 8'hF0);
    chk("t2_rr_second", log_d[base+3], 8'hF2);

    // Backpressure: m_rdy 1,0,0 repeating during a 4-byte packet.
    rdy_mode = 1;
    base = log_d.size();
    load(1, 4, 64'h64_63_62_61, 0);
    run(120, -1, 0);
    rdy_mode = 0;
    for (int k = 0; k < 5; k++) chk("t3_seq", log_d[base+k], t3e[k]);
    chk("t3_len", log_d.size() - base, 5);

    // Source stall: src2 pauses 10 cycles after 2 bytes while src0 requests.
    base = log_d.size();
    load(2, 5, 64'hA4_A3_A2_A1_A0, 0);
    stall_at[2] = 2; stall_len[2] = 10;
    load(0, 2, 64'hB1_B0, 4);
    stall_chk = 1'b1;
    run(120, -1, 0);
    stall_chk = 1'b0;
    chk("t4_first", log_d[base], 8'hF2);
    chk("t4_second", log_d[base+6], 8'hF0);
    chk("t4_len", log_d.size() - base, 9);

    // Reset mid-packet after 2 of 5 bytes.
    load(1, 5, 64'hC4_C3_C2_C1_C0, 0);
    run(60, 1, 2);
    chk("t5_grant_before", bus.grant_id, 1);
    reset = 1'b1;
    for (int s = 0; s < N; s++) pact[s] = 1'b0;
    bus.s_vld = '0; bus.s_last = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t5_m_vld", bus.m_vld, 0);
    chk("t5_s_rdy", bus.s_rdy, 0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_grant_id", bus.grant_id, 0);
    @(posedge clk); #1;
    base = log_d.size();
    load(0, 2, 64'hD1_D0, 0);
    load(1, 1, 64'hE0, 0);
    run(60, -1, 0);
    chk("t5_hdr0", log_d[base], 8'hF0);
    chk("t5_byte0", log_d[base+1], 8'hD0);
    chk("t5_hdr1", log_d[base+3], 8'hF1);

    // HDR_EN=0 instance: single-byte packet 5A from src1.
    bus0.s_vld = 3'b010; bus0.s_data = 24'h005A00; bus0.s_last = 3'b010;
    n = 0; got = 1'b0;
    while (n < 8 && !got) begin
      @(negedge clk);
      if (bus0.s_rdy[1]) begin
        got = 1'b1;
        chk("h0_no_header", bus0.m_vld, 0);
      end else begin
        n++;
        @(posedge clk); #1;
      end
    end
    chk("h0_latency", n, 1);
    @(posedge clk); #1;
    bus0.s_vld = '0; bus0.s_last = '0;
    @(negedge clk);
    chk("h0_m_vld", bus0.m_vld, 1);
    chk("h0_m_data", bus0.m_data, 8'h5A);
    chk("h0_m_last", bus0.m_last, 1);
    chk("h0_busy", bus0.busy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("h0_drained", bus0.m_vld, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
